// File: rtl/reset_seq.sv
// reset_seq: synchronised reset release with hold period and staggered per-channel deassertion.
module reset_seq #(
   parameter int SYNC_STAGES = 3,
   parameter int NUM_CH      = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGGER     = 4
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              sw_rst_req,
   output logic [NUM_CH-1:0] rst,
   output logic              rst_done,
   output logic              last_cause
);
   localparam int HW = $clog2(HOLD_CYCLES) + 1;
   localparam int SW = $clog2(STAGGER) + 1;
   typedef enum logic [1:0] {SYNC, HOLD, RELEASE, RUN} state_t;
   state_t state, state_nx;
   logic [SYNC_STAGES-1:0] sync;
   logic [HW-1:0] hcnt, hcnt_nx;
   logic [SW-1:0] scnt, scnt_nx;
   logic [NUM_CH-1:0] rst_nx, rst_sh;
   logic done_nx, cause_nx;
   assign rst_sh = rst << 1;
   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) sync <= '1;
      else sync <= {sync[SYNC_STAGES-2:0], 1'b0};
   // HOLD is entered on the edge that clears the last synchroniser stage
   always_comb begin
      state_nx = state;
      hcnt_nx  = hcnt;
      scnt_nx  = scnt;
      rst_nx   = rst;
      done_nx  = rst_done;
      cause_nx = last_cause;
      if (state == SYNC) begin
         if (sync == {1'b1, {(SYNC_STAGES-1){1'b0}}}) begin
            state_nx = HOLD;
            hcnt_nx  = '0;
         end
      end else if (sw_rst_req) begin
         state_nx = HOLD;
         hcnt_nx  = '0;
         scnt_nx  = '0;
         rst_nx   = '1;
         done_nx  = 1'b0;
         cause_nx = 1'b1;
      end else if (state == HOLD) begin
         hcnt_nx = hcnt + 1'b1;
         if (hcnt == HW'(HOLD_CYCLES - 1)) begin
            rst_nx   = rst_sh;
            scnt_nx  = '0;
            done_nx  = (rst_sh == '0);
            state_nx = (rst_sh == '0) ? RUN : RELEASE;
         end
      end else if (state == RELEASE) begin
         scnt_nx = scnt + 1'b1;
         if (scnt == SW'(STAGGER - 1)) begin
            rst_nx   = rst_sh;
            scnt_nx  = '0;
            done_nx  = (rst_sh == '0);
            state_nx = (rst_sh == '0) ? RUN : RELEASE;
         end
      end
   end
   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         state      <= SYNC;
         hcnt       <= '0;
         scnt       <= '0;
         rst        <= '1;
         rst_done   <= 1'b0;
         last_cause <= 1'b0;
      end else begin
         state      <= state_nx;
         hcnt       <= hcnt_nx;
         scnt       <= scnt_nx;
         rst        <= rst_nx;
         rst_done   <= done_nx;
         last_cause <= cause_nx;
      end
endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: directed vector checks of reset_seq boot timing, software resets and async abort.
module tb_reset_seq;
   typedef struct {
      int         e;
      logic [3:0] r;
      logic       d;
      logic       c;
   } vec_t;
   logic       clk = 1'b0;
   logic       arst_n, sw, arst2_n, sw2;
   logic [3:0] rst;
   logic       rst_done, last_cause;
   logic [0:0] rst2;
   logic       done2, cause2;
   int         ecnt, n_cmp, n_err;
   vec_t       boot[9];

   reset_seq dut (.clk(clk), .arst_n(arst_n), .sw_rst_req(sw), .rst(rst),
                  .rst_done(rst_done), .last_cause(last_cause));
   reset_seq #(.SYNC_STAGES(2), .NUM_CH(1), .HOLD_CYCLES(1), .STAGGER(4)) dut2 (
      .clk(clk), .arst_n(arst2_n), .sw_rst_req(sw2), .rst(rst2),
      .rst_done(done2), .last_cause(cause2));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      ecnt++;
   endtask

   task automatic upto(input int n);
      while (ecnt < n) tick();
   endtask

   task automatic chk(input string nm, input logic [3:0] r, input logic d, input logic c);
      n_cmp++;
      if ({rst, rst_done, last_cause} !== {r, d, c}) begin
         n_err++;
         $display("FAIL %s: got rst=%b done=%b cause=%b, want rst=%b done=%b cause=%b",
                  nm, rst, rst_done, last_cause, r, d, c);
      end
   endtask

   task automatic chk2(input string nm, input logic r, input logic d);
      n_cmp++;
      if ({rst2, done2, cause2} !== {r, d, 1'b0}) begin
         n_err++;
         $display("FAIL %s: got rst=%b done=%b cause=%b, want rst=%b done=%b cause=0",
                  nm, rst2, done2, cause2, r, d);
      end
   endtask

   task automatic run_boot(input string tag);
      for (int i = 0; i < 9; i++) begin
         upto(boot[i].e);
         chk($sformatf("%s_e%0d", tag, boot[i].e), boot[i].r, boot[i].d, boot[i].c);
      end
   endtask

   initial begin
      boot[0] = '{18, 4'b1111, 1'b0, 1'b0};
      boot[1] = '{19, 4'b1110, 1'b0, 1'b0};
      boot[2] = '{22, 4'b1110, 1'b0, 1'b0};
      boot[3] = '{23, 4'b1100, 1'b0, 1'b0};
      boot[4] = '{26, 4'b1100, 1'b0, 1'b0};
      boot[5] = '{27, 4'b1000, 1'b0, 1'b0};
      boot[6] = '{30, 4'b1000, 1'b0, 1'b0};
      boot[7] = '{31, 4'b0000, 1'b1, 1'b0};
      boot[8] = '{33, 4'b0000, 1'b1, 1'b0};
      n_cmp = 0;
      n_err = 0;
      ecnt = 0;
      arst_n = 1'b0;
      arst2_n = 1'b0;
      sw = 1'b0;
      sw2 = 1'b0;
      #12;
      chk("reset_state", 4'b1111, 1'b0, 1'b0);
      chk2("reset_state2", 1'b1, 1'b0);
      // boot with sw_rst_req held through the whole SYNC phase
      @(negedge clk);
      arst_n = 1'b1;
      sw = 1'b1;
      ecnt = 0;
      upto(3);
      sw = 1'b0;
      run_boot("boot");
      // single-cycle software reset in RUN
      sw = 1'b1;
      tick();
      chk("sw_assert", 4'b1111, 1'b0, 1'b1);
      sw = 1'b0;
      ecnt = 0;
      upto(15);
      chk("sw_hold15", 4'b1111, 1'b0, 1'b1);
      tick();
      chk("sw_rel0", 4'b1110, 1'b0, 1'b1);
      upto(27);
      chk("sw_e27", 4'b1000, 1'b0, 1'b1);
      tick();
      chk("sw_done", 4'b0000, 1'b1, 1'b1);
      // software reset two edges after rst[0] releases
      sw = 1'b1;
      tick();
      sw = 1'b0;
      ecnt = 0;
      upto(16);
      chk("rr_rel0", 4'b1110, 1'b0, 1'b1);
      upto(17);
      sw = 1'b1;
      tick();
      chk("rr_assert", 4'b1111, 1'b0, 1'b1);
      sw = 1'b0;
      ecnt = 0;
      upto(15);
      chk("rr_hold15", 4'b1111, 1'b0, 1'b1);
      tick();
      chk("rr_rel0b", 4'b1110, 1'b0, 1'b1);
      // held request keeps HOLD at zero until it drops
      sw = 1'b1;
      tick();
      tick();
      tick();
      chk("held_assert", 4'b1111, 1'b0, 1'b1);
      sw = 1'b0;
      ecnt = 0;
      upto(15);
      chk("held_hold15", 4'b1111, 1'b0, 1'b1);
      tick();
      chk("held_rel0", 4'b1110, 1'b0, 1'b1);
      upto(19);
      chk("held_e19", 4'b1110, 1'b0, 1'b1);
      tick();
      chk("held_rel1", 4'b1100, 1'b0, 1'b1);
      // asynchronous abort mid-RELEASE, then full reboot
      #3;
      arst_n = 1'b0;
      #1;
      chk("arst_async", 4'b1111, 1'b0, 1'b0);
      @(negedge clk);
      arst_n = 1'b1;
      ecnt = 0;
      run_boot("reboot");
      // minimal configuration
      @(negedge clk);
      arst2_n = 1'b1;
      ecnt = 0;
      upto(2);
      chk2("min_e2", 1'b1, 1'b0);
      tick();
      chk2("min_e3", 1'b0, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
